// File: rtl/osc_freq_cal.sv
// Frequency-calibration controller for osc_core: binary-searches the linear varactor
// code against a target edge count per reference window, then gates edge injection.
module osc_freq_cal #(
    parameter int CNT_W      = 12,
    parameter int WIN_LOG2   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             cal_start,
    input  logic [CNT_W-1:0] target_count,
    input  logic [CNT_W-1:0] osc_cnt,
    input  logic             inj_req,
    output logic [4:0]       delay_con_lsb,
    output logic [7:0]       delay_con_msb,
    output logic             inj_en,
    output logic             cal_busy,
    output logic             cal_done,
    output logic [CNT_W-1:0] meas_count,
    output logic [8:0]       code_out
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW    = ((SET_W > WIN_LOG2) ? SET_W : WIN_LOG2) + 1;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WIN_LOAD    = TW'((1 << WIN_LOG2) - 1);
    localparam logic [8:0]    CODE_MAX    = 9'd287;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        MEAS,
        EVAL,
        DONE
    } state_t;

    state_t           state;
    logic [8:0]       code_r;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] start_cnt;
    logic [TW-1:0]    timer;

    logic [8:0] trial;
    logic [8:0] eval_code;

    // Coarse units become a thermometer: u units -> lowest u bits set.
    function automatic logic [7:0] therm(input logic [3:0] units);
        logic [7:0] t;
        t = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            t[i] = (i < 32'(units));
        end
        return t;
    endfunction

    always_comb begin
        trial     = code_r | (9'd1 << bit_idx);
        eval_code = (meas_count > target_r) ? trial : code_r;
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state         <= IDLE;
            code_r        <= '0;
            bit_idx       <= '0;
            target_r      <= '0;
            start_cnt     <= '0;
            timer         <= '0;
            delay_con_lsb <= '0;
            delay_con_msb <= '0;
            code_out      <= '0;
            inj_en        <= 1'b0;
            cal_busy      <= 1'b0;
            cal_done      <= 1'b0;
            meas_count    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    inj_en <= (state == DONE) ? inj_req : 1'b0;
                    if (cal_start) begin
                        code_r   <= '0;
                        bit_idx  <= 4'd8;
                        target_r <= target_count;
                        cal_busy <= 1'b1;
                        cal_done <= 1'b0;
                        inj_en   <= 1'b0;
                        state    <= APPLY;
                    end
                end

                APPLY: begin
                    if (trial > CODE_MAX) begin
                        // Out-of-range trial: reject the bit without spending a window.
                        if (bit_idx == 4'd0) begin
                            code_out      <= code_r;
                            delay_con_lsb <= code_r[4:0];
                            delay_con_msb <= therm(code_r[8:5]);
                            cal_busy      <= 1'b0;
                            cal_done      <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                        end
                    end else begin
                        code_out      <= trial;
                        delay_con_lsb <= trial[4:0];
                        delay_con_msb <= therm(trial[8:5]);
                        timer         <= SETTLE_LOAD;
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (timer == '0) begin
                        start_cnt <= osc_cnt;
                        timer     <= WIN_LOAD;
                        state     <= MEAS;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                MEAS: begin
                    if (timer == '0) begin
                        // Modular difference absorbs a single wrap of the free-running count.
                        meas_count <= osc_cnt - start_cnt;
                        state      <= EVAL;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                EVAL: begin
                    code_r <= eval_code;
                    if (bit_idx == 4'd0) begin
                        code_out      <= eval_code;
                        delay_con_lsb <= eval_code[4:0];
                        delay_con_msb <= therm(eval_code[8:5]);
                        cal_busy      <= 1'b0;
                        cal_done      <= 1'b1;
                        state         <= DONE;
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                        state   <= APPLY;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_freq_cal.sv
// Directed bench for osc_freq_cal: a linear oscillator plant (count = 400 - C per window)
// or a fixed-rate plant drives osc_cnt; results are checked against hand-derived values.
module tb_osc_freq_cal;

    logic        ref_clk = 1'b0;
    logic        rst;
    logic        cal_start;
    logic [11:0] target_count;
    logic [11:0] osc_cnt;
    logic        inj_req;
    logic [4:0]  delay_con_lsb;
    logic [7:0]  delay_con_msb;
    logic        inj_en;
    logic        cal_busy;
    logic        cal_done;
    logic [11:0] meas_count;
    logic [8:0]  code_out;

    int total = 0;
    int bad   = 0;

    // Plant: acc/16 advances by the per-window count, so a 16-cycle window sees it exactly.
    logic [31:0] acc = '0;
    logic        fixed_mode = 1'b0;
    logic [31:0] fixed_rate = 32'd20;
    int          changes = 0;
    logic [8:0]  prev_code = '0;

    osc_freq_cal #(.CNT_W(12), .WIN_LOG2(4), .SETTLE_CYC(8)) dut (
        .ref_clk       (ref_clk),
        .rst           (rst),
        .cal_start     (cal_start),
        .target_count  (target_count),
        .osc_cnt       (osc_cnt),
        .inj_req       (inj_req),
        .delay_con_lsb (delay_con_lsb),
        .delay_con_msb (delay_con_msb),
        .inj_en        (inj_en),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done),
        .meas_count    (meas_count),
        .code_out      (code_out)
    );

    always #5 ref_clk = ~ref_clk;

    assign osc_cnt = acc[15:4];

    always @(negedge ref_clk) begin
        acc = acc + (fixed_mode ? fixed_rate : (32'd400 - 32'(code_out)));
        if (code_out !== prev_code) changes = changes + 1;
        prev_code = code_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a search; optionally pulse cal_start again so that it is sampled at edge pulse_at.
    task automatic run_cal(input logic [11:0] tgt, input int pulse_at, output int cycles);
        int n;
        @(negedge ref_clk);
        target_count = tgt;
        cal_start    = 1'b1;
        @(negedge ref_clk);
        cal_start = 1'b0;
        chk("busy_after_start", 32'(cal_busy), 32'd1);
        n = 0;
        while (!cal_done && n < 1000) begin
            if (n + 1 == pulse_at) cal_start = 1'b1;
            @(negedge ref_clk);
            cal_start = 1'b0;
            n++;
        end
        cycles = n;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_code"}, 32'(code_out), 32'd0);
        chk({tag, "_msb"},  32'(delay_con_msb), 32'd0);
        chk({tag, "_lsb"},  32'(delay_con_lsb), 32'd0);
        chk({tag, "_inj"},  32'(inj_en), 32'd0);
        chk({tag, "_busy"}, 32'(cal_busy), 32'd0);
        chk({tag, "_done"}, 32'(cal_done), 32'd0);
        chk({tag, "_meas"}, 32'(meas_count), 32'd0);
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        cal_start    = 1'b1;
        target_count = 12'd200;
        inj_req      = 1'b1;
        repeat (3) @(negedge ref_clk);
        rst       = 1'b0;
        cal_start = 1'b0;
        inj_req   = 1'b0;
        chk_zero("reset");
        @(negedge ref_clk);
        chk("reset_idle_busy", 32'(cal_busy), 32'd0);

        // Target 200 -> C = 199 (units 6, lsb 7)
        run_cal(12'd200, 0, cyc);
        chk("t200_cycles", 32'(cyc), 32'd234);
        chk("t200_code", 32'(code_out), 32'd199);
        chk("t200_msb", 32'(delay_con_msb), 32'h3F);
        chk("t200_lsb", 32'(delay_con_lsb), 32'd7);
        chk("t200_busy", 32'(cal_busy), 32'd0);
        chk("t200_inj_off", 32'(inj_en), 32'd0);
        chk("t200_meas", 32'(meas_count), 32'd201);
        inj_req = 1'b1;
        @(negedge ref_clk);
        chk("inj_on", 32'(inj_en), 32'd1);
        inj_req = 1'b0;
        @(negedge ref_clk);
        chk("inj_off", 32'(inj_en), 32'd0);
        inj_req = 1'b1;
        @(negedge ref_clk);

        // Restart from DONE clears done/inj; target 500 never exceeded -> C = 0
        run_cal(12'd500, 0, cyc);
        chk("t500_cycles", 32'(cyc), 32'd234);
        chk("t500_code", 32'(code_out), 32'd0);
        chk("t500_msb", 32'(delay_con_msb), 32'd0);
        chk("t500_lsb", 32'(delay_con_lsb), 32'd0);
        chk("t500_meas", 32'(meas_count), 32'd399);
        inj_req = 1'b0;
        @(negedge ref_clk);

        // Target 0 -> C = 287; bits 7,6,5 skipped, six windows
        changes = 0;
        run_cal(12'd0, 0, cyc);
        chk("t0_cycles", 32'(cyc), 32'd159);
        chk("t0_trials", 32'(changes), 32'd6);
        chk("t0_code", 32'(code_out), 32'd287);
        chk("t0_msb", 32'(delay_con_msb), 32'hFF);
        chk("t0_lsb", 32'(delay_con_lsb), 32'd31);

        // Wrap: count starts near 4090, 20 edges per window
        fixed_mode = 1'b1;
        acc        = 32'(12'd4080) << 4;
        run_cal(12'd10, 0, cyc);
        chk("wrap_meas", 32'(meas_count), 32'd20);
        chk("wrap_code", 32'(code_out), 32'd287);
        fixed_mode = 1'b0;

        // cal_start in MEAS (edge 20 of bit 8) is ignored
        run_cal(12'd200, 20, cyc);
        chk("midmeas_cycles", 32'(cyc), 32'd234);
        chk("midmeas_code", 32'(code_out), 32'd199);

        // Reset during SETTLE, then a clean run
        @(negedge ref_clk);
        target_count = 12'd200;
        cal_start    = 1'b1;
        @(negedge ref_clk);
        cal_start = 1'b0;
        repeat (4) @(negedge ref_clk);
        chk("settle_trial_code", 32'(code_out), 32'd256);
        rst = 1'b1;
        @(negedge ref_clk);
        rst = 1'b0;
        chk_zero("midrst");
        run_cal(12'd200, 0, cyc);
        chk("rerun_cycles", 32'(cyc), 32'd234);
        chk("rerun_code", 32'(code_out), 32'd199);
        chk("rerun_done", 32'(cal_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
